// File: rtl/sc_pkg.sv
// Shared types for the multi-channel charge controller.
//   grid_state_t : raw / debounced grid classification
//   ch_state_t   : per-channel FSM state
//   cnt_width()  : counter width able to hold 0..max_val, never narrower than 1
package sc_pkg;

  typedef enum logic [1:0] {
    GRID_OK    = 2'd0,
    GRID_SAG   = 2'd1,
    GRID_SWELL = 2'd2,
    GRID_LOSS  = 2'd3
  } grid_state_t;

  // CH_DISCONN is the one-cycle "enable already off, relay still closed" step
  // that breaks current before the contacts open.
  typedef enum logic [2:0] {
    CH_IDLE,
    CH_PRECHG,
    CH_CHARGING,
    CH_THROTTLE,
    CH_FAULT,
    CH_LOCKOUT,
    CH_DISCONN
  } ch_state_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sc_charge_channel.sv
// One charging channel: FSM, settle timer, retry wait timer, fault counter.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   charge_req_i        level request
//   fault_flag_i        level fault from safety logic
//   clear_lockout_i     pulse releasing LOCKOUT
//   grant_i             inrush token (one-hot across channels, from top)
//   sag_slot_i          channel may keep current flowing during GRID_SAG
//   grid_i              debounced grid state
//   charge_enable_o     registered charger enable
//   relay_activation_o  registered contactor drive
//   lockout_o           registered lockout flag
//   idle_o/prechg_o/active_o  state decode for the top-level arbiters
module sc_charge_channel
  import sc_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned RETRY_CYC   = 1024,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        charge_req_i,
  input  logic        fault_flag_i,
  input  logic        clear_lockout_i,
  input  logic        grant_i,
  input  logic        sag_slot_i,
  input  grid_state_t grid_i,
  output logic        charge_enable_o,
  output logic        relay_activation_o,
  output logic        lockout_o,
  output logic        idle_o,
  output logic        prechg_o,
  output logic        active_o
);

  localparam int unsigned SW = cnt_width(SETTLE_CYC);
  localparam int unsigned WW = cnt_width(RETRY_CYC);
  localparam int unsigned RW = cnt_width(MAX_RETRIES);

  ch_state_t     state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          en_d, relay_d, lock_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    wait_d   = wait_q;
    retry_d  = retry_q;

    if (state_q != CH_LOCKOUT && fault_flag_i) begin
      // A fault seen while already waiting only restarts the wait; the retry
      // count tracks distinct fault entries, not cycles of a held level.
      wait_d = '0;
      if (state_q != CH_FAULT) begin
        if (retry_q == RW'(MAX_RETRIES)) begin
          state_d = CH_LOCKOUT;
        end else begin
          state_d = CH_FAULT;
          retry_d = retry_q + RW'(1);
        end
      end
    end else if (state_q != CH_LOCKOUT && grid_i == GRID_LOSS) begin
      state_d = CH_IDLE;
    end else begin
      unique case (state_q)
        CH_IDLE: begin
          if (!charge_req_i) retry_d = '0;
          if (grant_i) begin
            state_d  = CH_PRECHG;
            settle_d = '0;
          end
        end
        CH_PRECHG: begin
          if (!charge_req_i) begin
            state_d = CH_DISCONN;
          end else if (32'(settle_q) + 32'd1 >= SETTLE_CYC) begin
            state_d = (grid_i == GRID_OK) ? CH_CHARGING : CH_THROTTLE;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
        CH_CHARGING: begin
          if (!charge_req_i)
            state_d = CH_DISCONN;
          else if (grid_i == GRID_SWELL || (grid_i == GRID_SAG && !sag_slot_i))
            state_d = CH_THROTTLE;
        end
        CH_THROTTLE: begin
          if (!charge_req_i)
            state_d = CH_DISCONN;
          else if (grid_i == GRID_OK || (grid_i == GRID_SAG && sag_slot_i))
            state_d = CH_CHARGING;
        end
        CH_DISCONN: state_d = CH_IDLE;
        CH_FAULT: begin
          if (32'(wait_q) + 32'd1 >= RETRY_CYC) state_d = CH_IDLE;
          else                                  wait_d  = wait_q + WW'(1);
        end
        CH_LOCKOUT: begin
          if (clear_lockout_i && !fault_flag_i) begin
            state_d = CH_IDLE;
            retry_d = '0;
          end
        end
        default: state_d = CH_IDLE;
      endcase
    end

    relay_d = (state_d == CH_PRECHG) || (state_d == CH_CHARGING) ||
              (state_d == CH_THROTTLE) || (state_d == CH_DISCONN);
    en_d    = (state_d == CH_CHARGING);
    lock_d  = (state_d == CH_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= CH_IDLE;
      settle_q           <= '0;
      wait_q             <= '0;
      retry_q            <= '0;
      charge_enable_o    <= 1'b0;
      relay_activation_o <= 1'b0;
      lockout_o          <= 1'b0;
    end else begin
      state_q            <= state_d;
      settle_q           <= settle_d;
      wait_q             <= wait_d;
      retry_q            <= retry_d;
      charge_enable_o    <= en_d;
      relay_activation_o <= relay_d;
      lockout_o          <= lock_d;
    end
  end

  assign idle_o   = (state_q == CH_IDLE);
  assign prechg_o = (state_q == CH_PRECHG);
  assign active_o = (state_q == CH_CHARGING) || (state_q == CH_THROTTLE);

endmodule

// File: rtl/sc_multi_charge_ctrl.sv
// N-channel charge controller: grid debouncer, inrush-token arbiter,
// sag-slot allocator and one sc_charge_channel per channel.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   grid_state        raw grid classification
//   charge_req        per-channel request (level)
//   fault_flag        per-channel fault (level)
//   clear_lockout     per-channel LOCKOUT release pulse
//   charge_enable     charger current enable
//   relay_activation  contactor drive
//   lockout           channel is in LOCKOUT
//   grid_state_q      debounced grid state
module sc_multi_charge_ctrl
  import sc_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned SETTLE_CYC   = 8,
  parameter int unsigned RETRY_CYC    = 1024,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned MAX_SAG_CH   = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  grid_state_t     grid_state,
  input  logic [N_CH-1:0] charge_req,
  input  logic [N_CH-1:0] fault_flag,
  input  logic [N_CH-1:0] clear_lockout,
  output logic [N_CH-1:0] charge_enable,
  output logic [N_CH-1:0] relay_activation,
  output logic [N_CH-1:0] lockout,
  output grid_state_t     grid_state_q
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYC);

  grid_state_t     cand_q, cand_d, grid_state_d;
  logic [DW-1:0]   dbc_q, dbc_d;
  logic [N_CH-1:0] idle, prechg, active, grant, sag_slot;

  // Debounce: dbc counts consecutive samples equal to the candidate,
  // including the current one. LOSS bypasses the count entirely.
  always_comb begin
    cand_d = grid_state;
    if (grid_state == cand_q)
      dbc_d = (dbc_q == DW'(DEBOUNCE_CYC)) ? dbc_q : dbc_q + DW'(1);
    else
      dbc_d = DW'(1);
    grid_state_d = grid_state_q;
    if (grid_state == GRID_LOSS)
      grid_state_d = GRID_LOSS;
    else if (32'(dbc_d) >= DEBOUNCE_CYC)
      grid_state_d = grid_state;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand_q       <= GRID_LOSS;
      dbc_q        <= '0;
      grid_state_q <= GRID_LOSS;
    end else begin
      cand_q       <= cand_d;
      dbc_q        <= dbc_d;
      grid_state_q <= grid_state_d;
    end
  end

  // Inrush token: lowest-index eligible idle channel, only while nobody precharges.
  always_comb begin
    logic taken;
    grant = '0;
    taken = (|prechg) || (grid_state_q != GRID_OK);
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!taken && idle[i] && charge_req[i] && !fault_flag[i]) begin
        grant[i] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

  // Sag slots: the MAX_SAG_CH lowest-index CHARGING/THROTTLE channels.
  always_comb begin
    int unsigned n_active;
    sag_slot = '0;
    n_active = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (active[i]) begin
        if (n_active < MAX_SAG_CH) sag_slot[i] = 1'b1;
        n_active++;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sc_charge_channel #(
      .SETTLE_CYC (SETTLE_CYC),
      .RETRY_CYC  (RETRY_CYC),
      .MAX_RETRIES(MAX_RETRIES)
    ) u_ch (
      .clk               (clk),
      .reset_n           (reset_n),
      .charge_req_i      (charge_req[g]),
      .fault_flag_i      (fault_flag[g]),
      .clear_lockout_i   (clear_lockout[g]),
      .grant_i           (grant[g]),
      .sag_slot_i        (sag_slot[g]),
      .grid_i            (grid_state_q),
      .charge_enable_o   (charge_enable[g]),
      .relay_activation_o(relay_activation[g]),
      .lockout_o         (lockout[g]),
      .idle_o            (idle[g]),
      .prechg_o          (prechg[g]),
      .active_o          (active[g])
    );
  end

endmodule
